// File: rtl/hazard_if.sv
// Control-path bundle between the ID stage and the hazard scoreboard.
interface hazard_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 3
);
   localparam int NUM_REGS = 2 ** REG_AW;

   logic                ID_valid;
   logic [REG_AW-1:0]   ID_rs1;
   logic [REG_AW-1:0]   ID_rs2;
   logic                ID_use_rs1;
   logic                ID_use_rs2;
   logic [REG_AW-1:0]   ID_rd;
   logic [CNT_W-1:0]    ID_rd_lat;
   logic                branch_taken;
   logic                pipe_hold;
   logic                stall;
   logic                flush;
   logic                issue;
   logic [NUM_REGS-1:0] busy_vec;

   modport master (
      output ID_valid, ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2,
             ID_rd, ID_rd_lat, branch_taken, pipe_hold,
      input  stall, flush, issue, busy_vec
   );

   modport slave (
      input  ID_valid, ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2,
             ID_rd, ID_rd_lat, branch_taken, pipe_hold,
      output stall, flush, issue, busy_vec
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register latency countdown scoreboard producing IF/ID stall, flush and
// issue, with a multi-cycle branch flush window and a global pipeline hold.
module hazard_scoreboard #(
   parameter int REG_AW       = 5,
   parameter int CNT_W        = 3,
   parameter int MAX_LAT      = 4,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic     clk,
   input  logic     reset,
   hazard_if.slave  hz
);
   localparam int NUM_REGS = 2 ** REG_AW;
   localparam int FC_W     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FC_W-1:0] FC_LOAD = (FLUSH_CYCLES > 1) ? FC_W'(FLUSH_CYCLES - 1) : '0;

   generate
      if (MAX_LAT > (2 ** CNT_W) - 1) begin : g_bad_lat
         $error("MAX_LAT does not fit in CNT_W bits");
      end
   endgenerate

   logic [CNT_W-1:0]    cnt_q [NUM_REGS];
   logic [CNT_W-1:0]    cnt_d [NUM_REGS];
   logic [FC_W-1:0]     fcnt_q;
   logic [FC_W-1:0]     fcnt_d;
   logic                raw_hz_s;
   logic                flush_s;
   logic                stall_s;
   logic                issue_s;
   logic                load_s;
   logic [NUM_REGS-1:0] busy_s;

   // Hazard detection; a dead (flushed) instruction never raises a RAW stall.
   always_comb begin
      raw_hz_s = (hz.ID_use_rs1 && (hz.ID_rs1 != '0) && (cnt_q[hz.ID_rs1] != '0)) ||
                 (hz.ID_use_rs2 && (hz.ID_rs2 != '0) && (cnt_q[hz.ID_rs2] != '0));
      flush_s  = !hz.pipe_hold && (hz.branch_taken || (fcnt_q != '0));
      stall_s  = hz.pipe_hold || (hz.ID_valid && raw_hz_s && !flush_s);
      issue_s  = hz.ID_valid && !stall_s && !flush_s;
      load_s   = issue_s && (hz.ID_rd != '0) && (hz.ID_rd_lat != '0);
   end

   // Next-state for flush window and counters; a new load overrides the decrement.
   always_comb begin
      if (hz.pipe_hold) begin
         fcnt_d = fcnt_q;
      end else if (hz.branch_taken) begin
         fcnt_d = FC_LOAD;
      end else if (fcnt_q != '0) begin
         fcnt_d = fcnt_q - FC_W'(1);
      end else begin
         fcnt_d = fcnt_q;
      end
      for (int r = 0; r < NUM_REGS; r++) begin
         busy_s[r] = (cnt_q[r] != '0);
         if (load_s && (hz.ID_rd == REG_AW'(r))) begin
            cnt_d[r] = hz.ID_rd_lat;
         end else if (!hz.pipe_hold && (cnt_q[r] != '0)) begin
            cnt_d[r] = cnt_q[r] - CNT_W'(1);
         end else begin
            cnt_d[r] = cnt_q[r];
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= '0;
         end
         fcnt_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         fcnt_q <= fcnt_d;
      end
   end

   assign hz.stall    = stall_s;
   assign hz.flush    = flush_s;
   assign hz.issue    = issue_s;
   assign hz.busy_vec = busy_s;
endmodule
